// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store unit with byte/halfword read-modify-write, rev 1.0.
// Optional MISALIGN_EXC_EN enables alignment and range address-error detection.
`default_nettype none

module mem_access_unit #(
   parameter logic [31:0] ADDR_LIMIT = 32'h0000_3000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        op_valid,
   input  logic [2:0]  op_type,
   input  logic [31:0] op_addr,
   input  logic [31:0] op_wdata,
   input  logic [31:0] op_pc,
   output logic        busy,
   output logic        rdata_valid,
   output logic [31:0] rdata,
   output logic        exc_adel,
   output logic        exc_ades,
   output logic [31:0] dm_addr,
   output logic [31:0] dm_wd,
   output logic        dm_we,
   output logic        dm_req,
   input  logic [31:0] dm_rd
);

   localparam logic [2:0] OP_LW  = 3'd0;
   localparam logic [2:0] OP_LB  = 3'd1;
   localparam logic [2:0] OP_LBU = 3'd2;
   localparam logic [2:0] OP_LH  = 3'd3;
   localparam logic [2:0] OP_LHU = 3'd4;
   localparam logic [2:0] OP_SW  = 3'd5;
   localparam logic [2:0] OP_SB  = 3'd6;
   localparam logic [2:0] OP_SH  = 3'd7;

   typedef enum logic [0:0] {IDLE = 1'b0, RMW_WR = 1'b1} state_t;

   state_t      state;
   logic [31:0] rmw_addr;
   logic [31:0] rmw_data;

   logic        is_load;
   logic        is_rmw;
   logic        accept;
   logic        addr_err;
   logic [31:0] aligned_addr;
   logic [7:0]  lane_byte;
   logic [15:0] lane_half;
   logic [31:0] load_val;
   logic [31:0] merged;
   logic        unused_bits;

   assign is_load      = (op_type <= OP_LHU);
   assign is_rmw       = (op_type == OP_SB) || (op_type == OP_SH);
   assign accept       = (state == IDLE) && op_valid;
   assign aligned_addr = {op_addr[31:2], 2'b00};

`ifdef MISALIGN_EXC_EN
   assign addr_err = (((op_type == OP_LH) || (op_type == OP_LHU) || (op_type == OP_SH)) && op_addr[0])
                   || (((op_type == OP_LW) || (op_type == OP_SW)) && (op_addr[1:0] != 2'b00))
                   || (op_addr >= ADDR_LIMIT);
   assign unused_bits = ^op_pc;
`else
   assign addr_err    = 1'b0;
   assign unused_bits = ^{op_pc, ADDR_LIMIT};
`endif

   always_comb begin
      lane_byte = dm_rd[7:0];
      case (op_addr[1:0])
         2'd0: lane_byte = dm_rd[7:0];
         2'd1: lane_byte = dm_rd[15:8];
         2'd2: lane_byte = dm_rd[23:16];
         2'd3: lane_byte = dm_rd[31:24];
         default: lane_byte = dm_rd[7:0];
      endcase
      lane_half = op_addr[1] ? dm_rd[31:16] : dm_rd[15:0];

      load_val = dm_rd;
      case (op_type)
         OP_LB:   load_val = {{24{lane_byte[7]}}, lane_byte};
         OP_LBU:  load_val = {24'h0, lane_byte};
         OP_LH:   load_val = {{16{lane_half[15]}}, lane_half};
         OP_LHU:  load_val = {16'h0, lane_half};
         default: load_val = dm_rd;
      endcase

      merged = dm_rd;
      if (op_type == OP_SB) begin
         case (op_addr[1:0])
            2'd0: merged[7:0]   = op_wdata[7:0];
            2'd1: merged[15:8]  = op_wdata[7:0];
            2'd2: merged[23:16] = op_wdata[7:0];
            2'd3: merged[31:24] = op_wdata[7:0];
            default: merged = dm_rd;
         endcase
      end else if (op_addr[1]) begin
         merged[31:16] = op_wdata[15:0];
      end else begin
         merged[15:0] = op_wdata[15:0];
      end
   end

   // Writes are gated by reset so a reset landing on RMW_WR abandons the merged word.
   assign dm_addr = (state == RMW_WR) ? rmw_addr : aligned_addr;
   assign dm_wd   = (state == RMW_WR) ? rmw_data : op_wdata;
   assign dm_we   = reset && ((state == RMW_WR) || (accept && (op_type == OP_SW) && !addr_err));
   assign dm_req  = !dm_we;
   assign busy    = (state == RMW_WR) || (accept && is_rmw && !addr_err);

   always_ff @(posedge clk) begin
      if (!reset) begin
         state       <= IDLE;
         rdata       <= 32'h0;
         rdata_valid <= 1'b0;
         exc_adel    <= 1'b0;
         exc_ades    <= 1'b0;
         rmw_addr    <= 32'h0;
         rmw_data    <= 32'h0;
      end else begin
         rdata_valid <= 1'b0;
         exc_adel    <= 1'b0;
         exc_ades    <= 1'b0;
         case (state)
            IDLE: begin
               if (op_valid) begin
                  if (addr_err) begin
                     exc_adel <= is_load;
                     exc_ades <= !is_load;
                  end else if (is_load) begin
                     rdata       <= load_val;
                     rdata_valid <= 1'b1;
                  end else if (is_rmw) begin
                     rmw_addr <= aligned_addr;
                     rmw_data <= merged;
                     state    <= RMW_WR;
                  end
               end
            end
            RMW_WR:  state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

`default_nettype wire
